// File: rtl/cacheline_adaptor_pkg.sv
// Shared widths, state encoding and address helper for the
// cache-line to memory-burst adaptor.
package cacheline_adaptor_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int ADDR_W = 32;
    localparam int OFFS_W = 5;
    localparam int CNT_W  = 2;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } cacheline_adaptor_state_t;

    function automatic logic [ADDR_W-1:0] align_line(
        input logic [ADDR_W-1:0] a
    );
        return {a[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits 256-bit line reads/writes into four 64-bit memory beats
// and reassembles read beats into a line for the arbiter.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,

    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    cacheline_adaptor_state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LINE_W-1:0] line_q,  line_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic [BEAT_W-1:0] beat_sel;

    // line_q is the working buffer (read assembly / write source);
    // rdata_q keeps the last completed read so writes never disturb line_o.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        line_d   = line_q;
        rdata_d  = rdata_q;
        beat_sel = line_q[BEAT_W*cnt_q +: BEAT_W];

        case (state_q)
            IDLE: begin
                if (read_i) begin
                    addr_d  = align_line(address_i);
                    cnt_d   = '0;
                    state_d = RD;
                end else if (write_i) begin
                    addr_d  = align_line(address_i);
                    line_d  = line_i;
                    cnt_d   = '0;
                    state_d = WR;
                end
            end
            RD: begin
                if (resp_i) begin
                    line_d[BEAT_W*cnt_q +: BEAT_W] = burst_i;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        rdata_d = line_d;
                        state_d = DONE;
                    end
                end
            end
            WR: begin
                if (resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
        end
    end

    assign read_o    = (state_q == RD);
    assign write_o   = (state_q == WR);
    assign resp_o    = (state_q == DONE);
    assign address_o = addr_q;
    assign burst_o   = (state_q == WR) ? beat_sel : '0;
    assign line_o    = rdata_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: vector table plus
// hand-written reset, spurious-response and abort sequences.
module tb_cacheline_adaptor;
    import cacheline_adaptor_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic [BEAT_W-1:0]  burst_i;
    logic [BEAT_W-1:0]  burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    typedef struct {
        string         name;
        bit            rd;
        bit            wr;
        logic [31:0]   addr;
        logic [255:0]  wline;
        logic [255:0]  mem;
        logic [15:0]   pat;
        int            plen;
        logic [31:0]   exp_addr;
        int            exp_lat;
    } vec_t;

    typedef struct {
        string         tag;
        logic [255:0]  val;
    } sb_t;

    sb_t          sb_q[$];
    vec_t         tv[5];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [255:0] line_model;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input string nm, input logic [255:0] act);
        sb_t it;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s actual=%h required=<queue empty>", nm, act);
        end else begin
            it = sb_q.pop_front();
            chk({nm, "_", it.tag}, act, it.val);
        end
    endtask

    task automatic run(input vec_t v);
        int n;
        int pi;
        int beats;
        bit done;
        bit rnow;
        if (v.rd) begin
            sb_q.push_back('{"line", v.mem});
        end else begin
            for (int i = 0; i < 4; i++)
                sb_q.push_back('{$sformatf("beat%0d", i),
                                 {192'b0, v.wline[64*i +: 64]}});
        end
        @(negedge clk);
        read_i    = v.rd;
        write_i   = v.wr;
        address_i = v.addr;
        line_i    = v.wline;
        resp_i    = 1'b0;
        n = 0; pi = 0; beats = 0; done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            read_i  = 1'b0;
            write_i = 1'b0;
            resp_i  = 1'b0;
            if (resp_o) begin
                done = 1'b1;
            end else begin
                if (n == 1)
                    chk({v.name, "_req_lat"}, v.rd ? read_o : write_o, 1);
                if (v.rd)
                    chk({v.name, "_no_write_o"}, write_o, 0);
                chk({v.name, "_address_o"}, address_o, v.exp_addr);
                rnow = (pi < v.plen) ? v.pat[pi] : 1'b1;
                pi++;
                if (rnow) begin
                    if (v.rd) burst_i = v.mem[64*beats +: 64];
                    else      pop_chk(v.name, burst_o);
                    beats++;
                end
                resp_i = rnow;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout actual=no resp_o required=resp_o",
                     v.name);
        end
        chk({v.name, "_latency"}, n, v.exp_lat);
        chk({v.name, "_read_o_done"}, read_o, 0);
        chk({v.name, "_write_o_done"}, write_o, 0);
        if (v.rd) begin
            pop_chk(v.name, line_o);
            line_model = v.mem;
        end else begin
            chk({v.name, "_line_hold"}, line_o, line_model);
        end
        @(negedge clk);
        chk({v.name, "_resp_pulse"}, resp_o, 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_read_o"}, read_o, 0);
        chk({nm, "_write_o"}, write_o, 0);
        chk({nm, "_resp_o"}, resp_o, 0);
        chk({nm, "_address_o"}, address_o, 0);
        chk({nm, "_burst_o"}, burst_o, 0);
        chk({nm, "_line_o"}, line_o, 0);
    endtask

    initial begin
        vec_t rv;
        tv[0] = '{"read", 1, 0, 32'h0000_1234, '0,
                  {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
                  16'h0, 0, 32'h0000_1220, 5};
        tv[1] = '{"write", 0, 1, 32'h0000_5678,
                  {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}},
                  '0, 16'h0, 0, 32'h0000_5660, 5};
        tv[2] = '{"gap_read", 1, 0, 32'h0000_0080, '0,
                  {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'hDEAD_BEEF_CAFE_F00D, 64'h0BAD_F00D_1234_5678},
                  16'b1011001, 7, 32'h0000_0080, 8};
        tv[3] = '{"rd_wr_both", 1, 1, 32'hFFFF_FFFF,
                  {4{64'h5555_AAAA_5555_AAAA}},
                  {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
                   64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001},
                  16'h0, 0, 32'hFFFF_FFE0, 5};
        tv[4] = '{"gap_write", 0, 1, 32'h0000_003F,
                  {64'h4000_0000_0000_0004, 64'h3000_0000_0000_0003,
                   64'h2000_0000_0000_0002, 64'h1000_0000_0000_0001},
                  '0, 16'b1100110, 7, 32'h0000_0020, 8};

        rst_n = 1'b0; line_i = '0; address_i = '0;
        read_i = 1'b0; write_i = 1'b0; burst_i = '0; resp_i = 1'b0;
        line_model = '0;
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run(tv[i]);

        // spurious responses while idle
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("spur_resp_o", resp_o, 0);
            chk("spur_read_o", read_o, 0);
            chk("spur_line_o", line_o, line_model);
            resp_i  = 1'b1;
            burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        @(negedge clk);
        resp_i = 1'b0;
        chk("spur_after_resp_o", resp_o, 0);
        chk("spur_after_line_o", line_o, line_model);

        // abort a read after two beats
        @(negedge clk);
        read_i = 1'b1; address_i = 32'h0000_0200;
        @(negedge clk);
        read_i = 1'b0; resp_i = 1'b1; burst_i = 64'hEEEE_0000_0000_0000;
        @(negedge clk);
        burst_i = 64'hEEEE_1111_0000_0000;
        @(negedge clk);
        resp_i = 1'b0;
        chk("abort_read_o", read_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("abort");
        line_model = '0;
        @(negedge clk);
        rst_n = 1'b1;

        rv = '{"post_abort", 1, 0, 32'h0000_0040, '0,
               {64'h0000_0000_0000_0D04, 64'h0000_0000_0000_0C03,
                64'h0000_0000_0000_0B02, 64'h0000_0000_0000_0A01},
               16'b101, 3, 32'h0000_0040, 6};
        run(rv);

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
